// File: rtl/countdown_controller.sv
// Loadable down-counter with start/terminal-count control and LED-style count output.
// Optional build macro COUNTDOWN_CONTROLLER_STICKY_TC_EN holds output_tc high throughout one-shot DONE.
//
// state   | meaning
// --------+------------------------------------------------------
// ST_IDLE | waiting; reload value may be loaded, start honoured
// ST_RUN  | counting down on enabled cycles
// ST_DONE | one-shot countdown finished; count parked at 0
module countdown_controller #(
  parameter int unsigned      WIDTH          = 3,
  parameter logic [WIDTH-1:0] RELOAD_DEFAULT = {WIDTH{1'b1}}
) (
  input  logic             input_clock1_1,
  input  logic             input_reset1_2,
  input  logic             input_load_valid,
  input  logic [WIDTH-1:0] input_load_value,
  output logic             output_load_ready,
  input  logic             input_start,
  input  logic             input_enable,
  input  logic             input_auto_reload,
  output logic [WIDTH-1:0] output_count,
  output logic             output_busy,
  output logic             output_tc
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             load_ready_q, load_ready_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (input_load_valid) begin
          reload_d = input_load_value;
          count_d  = input_load_value;
          state_d  = ST_IDLE;
        end
        // A same-cycle load takes priority as the start value.
        if (input_start) begin
          count_d = input_load_valid ? input_load_value : reload_q;
          state_d = ST_RUN;
        end
`ifdef COUNTDOWN_CONTROLLER_STICKY_TC_EN
        if ((state_q == ST_DONE) && !input_load_valid && !input_start) begin
          tc_d = 1'b1;
        end
`endif
      end

      ST_RUN: begin
        if (input_enable) begin
          if (count_q == '0) begin
            tc_d = 1'b1;
            if (input_auto_reload) begin
              count_d = reload_q;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase

    busy_d       = (state_d == ST_RUN);
    load_ready_d = (state_d != ST_RUN);
  end

  always_ff @(posedge input_clock1_1) begin
    if (input_reset1_2) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      reload_q     <= RELOAD_DEFAULT;
      tc_q         <= 1'b0;
      busy_q       <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      reload_q     <= reload_d;
      tc_q         <= tc_d;
      busy_q       <= busy_d;
      load_ready_q <= load_ready_d;
    end
  end

  assign output_count      = count_q;
  assign output_busy       = busy_q;
  assign output_load_ready = load_ready_q;
  assign output_tc         = tc_q;

endmodule
